hazard_ctrl: RTL

Pipeline sequencing controller for the five-stage xgriscv datapath. It tracks destination registers in flight through E/M/W in shadow registers and produces registered forwarding selects for the E-stage operand muxes. It also generates all stall and flush strobes: load-use bubbles, taken-branch/jump squashes, and a hold of the pipe while an iterative multiply/divide unit is busy. It sits beside the controller and drives the enables and clears of the IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/hazard_ctrl_pkg.sv | 29 ++
 rtl/hazard_ctrl_fwd_sel.sv | 24 ++
 rtl/hazard_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the xgriscv hazard controller: register index width,
// forwarding selects, sequencing states and the shadow/debug record layouts.
package hazard_ctrl_pkg;

    localparam int RFIDX_WIDTH = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_BUSY = 1'b1
    } hzState_e;

    typedef struct packed {
        logic [RFIDX_WIDTH-1:0] rd;
        logic                   regWrite;
        logic                   memToReg;
    } shadow_t;

    typedef struct packed {
        hzState_e state;
        shadow_t  e;
        shadow_t  m;
        shadow_t  w;
    } hzDebug_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Compares one source index against the instructions that will sit in M and W
// next cycle and picks the operand source for the E-stage mux.
import hazard_ctrl_pkg::*;

module fwd_sel (
    input  logic [RFIDX_WIDTH-1:0] rs,
    input  shadow_t                nextM,
    input  shadow_t                nextW,
    output logic [1:0]             sel
);

    // A load in M has no data yet; the load-use bubble lets the consumer see it in W.
    always_comb begin
        sel = FWD_REG;
        if (rs != '0) begin
            if (nextM.regWrite && !nextM.memToReg && (nextM.rd == rs)) begin
                sel = FWD_M;
            end else if (nextW.regWrite && (nextW.rd == rs)) begin
                sel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing for the five-stage xgriscv: shadow rd tracking, registered
// forwarding selects, load-use/branch stall+flush strobes and mul/div hold.
import hazard_ctrl_pkg::*;

module hazard_ctrl (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RFIDX_WIDTH-1:0] rs1D,
    input  logic [RFIDX_WIDTH-1:0] rs2D,
    input  logic                   use1D,
    input  logic                   use2D,
    input  logic [RFIDX_WIDTH-1:0] rdD,
    input  logic                   regwriteD,
    input  logic                   memtoregD,
    input  logic                   mdvD,
    input  logic                   pcsrcE,
    input  logic                   mdv_done,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   stallE,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   flushM,
    output logic [1:0]             fwdaE,
    output logic [1:0]             fwdbE,
    output logic                   mdv_start,
    output hzDebug_t               dbg
);

    hzState_e state;
    shadow_t  shD, shE, shM, shW;
    logic [1:0] selA, selB;
    logic busy, busyHold, loadUse, branchKill, advanceE;

    assign shD = {rdD, regwriteD, memtoregD};

    fwd_sel uFwdA (.rs(rs1D), .nextM(shE), .nextW(shM), .sel(selA));
    fwd_sel uFwdB (.rs(rs2D), .nextM(shE), .nextW(shM), .sel(selB));

    // While BUSY the E slot holds a mul/div, so branch and load-use checks are moot.
    always_comb begin
        busy       = (state == HZ_BUSY);
        busyHold   = busy && !mdv_done;
        loadUse    = shE.memToReg && (shE.rd != '0) &&
                     ((use1D && (rs1D == shE.rd)) || (use2D && (rs2D == shE.rd)));
        branchKill = !busy && pcsrcE;
        stallF     = busyHold || (!busy && loadUse && !pcsrcE);
        stallD     = stallF;
        stallE     = busyHold;
        flushM     = busyHold;
        flushD     = branchKill;
        flushE     = branchKill || (!busy && loadUse);
        advanceE   = !stallE && !flushE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HZ_RUN;
            mdv_start <= 1'b0;
            shE       <= '0;
            shM       <= '0;
            shW       <= '0;
            fwdaE     <= FWD_REG;
            fwdbE     <= FWD_REG;
        end else begin
            mdv_start <= advanceE && mdvD;
            if (advanceE && mdvD) begin
                state <= HZ_BUSY;
            end else if (busy && mdv_done) begin
                state <= HZ_RUN;
            end

            if (flushE) begin
                shE   <= '0;
                fwdaE <= FWD_REG;
                fwdbE <= FWD_REG;
            end else if (!stallE) begin
                shE   <= shD;
                fwdaE <= selA;
                fwdbE <= selB;
            end

            shM <= flushM ? '0 : shE;
            shW <= shM;
        end
    end

    assign dbg = '{state: state, e: shE, m: shM, w: shW};

endmodule
